rsqrt_seeded_iterator: RTL
==========================

Name: rsqrt_seeded_iterator

Overview:
- Computes result ≈ 1/sqrt(number) for positive fixed_t values.
- Sits directly upstream of newtons_method_rsqrt and owns one instance of it.
- Forms a power-of-two seed guess from the input's leading-one position, then drives the Newton stage for a fixed number of passes, feeding each new_guess back as old_guess.
- Used by the normalisation path of the RANSAC plane fitter.

Parameters:
- iterations, 4: Newton passes per input. 0 is legal: the seed is returned directly.
- multiply_latency, ransac_fixed::value_bits() / 16: forwarded to the Newton stage.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- input_valid  input  1  number is valid.
- number  input  fixed_t  operand x.
- input_ready  output  1  block can accept; high only in IDLE.
- output_valid  output  1  result valid; held until output_ready.
- output_ready  input  1  consumer accepts result.
- result  output  fixed_t  1/sqrt(x) estimate; 0 when error.
- error  output  1  qualifies result; high when x <= 0.

Behaviour:
- Reset values: input_ready=1, output_valid=0, error=0, result=0, state=IDLE, pass counter=0.
- Reset also resets the child. A reset mid-operation discards the operation; no output is produced.
- Child number and old_guess are driven from registers that reset to ransac_fixed::one() and only ever load validated positive values. This keeps the child's simulation checks silent.
- Accept rule: input_valid && input_ready at a clock edge. input_ready drops the next cycle.
- States:
  - IDLE: on accept, latch x.
    - x <= 0: go to DONE with error=1, result=0. The child is never started.
    - Otherwise go to SEED.
  - SEED: compute the seed into the guess register.
    - p = index of the highest set bit of x.
    - e = p - fraction_bits (signed).
    - k = fraction_bits - ceil(e/2).
    - guess = 1 << k. If k > value_bits-2, saturate to the largest positive power of two. If k < 0, guess = 1 LSB.
    - Load the counter with iterations. Go to DONE if iterations==0, else ISSUE.
  - ISSUE: wait for child input_ready. Then assert child input_valid for exactly one cycle with number=x, old_guess=guess. Go to ACK.
  - ACK: wait for child input_ready==0. This guards against the child's output_valid still being high from the previous pass. Go to WAIT.
  - WAIT: on child output_valid:
    - guess <= new_guess and decrement the counter.
    - If the counter is now 0, go to DONE; else go to ISSUE.
  - DONE: output_valid=1, result=guess (or 0 on error).
    - Hold result/error stable until output_ready, then go to IDLE with input_ready=1 and output_valid=0.
    - input_valid is ignored while not in IDLE.
- Simultaneous output_ready and input_valid in DONE: only the output handshake completes. The new input is accepted in IDLE the following cycle.
- Seed choice guarantees g^2·x < 2, so Newton converges monotonically. No guard on the child output is needed.
- Latency: 2 cycles + iterations × (child latency + 2), plus output stall.

Decomposition:
- Add to ransac_fixed:
  - function fraction_bits();
  - function leading_one_index(fixed_t) returning int, with -1 for zero;
  - function rsqrt_seed(fixed_t) implementing the SEED rule above. It is shared with the future vector-normalise block.
- Sub-module: newtons_method_rsqrt, single instance, reset_polarity=1.

Test Plan (fraction_bits=16, one()=0x10000):
- number=0x40000 (4.0), iterations=4: seed 0x8000; result=0x8000 exactly; error=0.
- number=0x20000 (2.0): seed 0x8000; passes give ≈0.625, 0.6934, 0.7067; result=0xB505 ±2 LSB.
- number=0xFFFF0000 (negative) and number=0: output_valid with error=1, result=0; child input_valid never asserted.
- iterations=0, number=0x10000: result=0x10000 two cycles after accept; child never started.
- Hold output_ready=0 for 10 cycles after output_valid: result stable, input_ready=0, a pulsed input_valid is ignored. Then assert output_ready together with a new input: new input accepted one cycle later.
- Assert reset during WAIT of pass 2: next cycle input_ready=1 and output_valid=0. A following input 0x40000 completes normally with 0x8000.

Source files
------------

// File: rtl/rsqrt_seeded_iterator_pkg.sv
// Fixed-point format and seed helpers shared by the rsqrt iterator and the vector-normalise path.
// Q16.16 signed: 32 value bits, 16 fraction bits.
package rsqrt_seeded_iterator_pkg;

   localparam int VALUE_BITS = 32;
   localparam int FRAC_BITS  = 16;

   typedef logic signed [VALUE_BITS-1:0] fixed_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEED,
      S_ISSUE,
      S_ACK,
      S_WAIT,
      S_DONE
   } state_t;

   function automatic int value_bits();
      return VALUE_BITS;
   endfunction

   function automatic int fraction_bits();
      return FRAC_BITS;
   endfunction

   function automatic fixed_t one();
      return fixed_t'(1) <<< FRAC_BITS;
   endfunction

   function automatic int leading_one_index(fixed_t x);
      int idx;
      idx = -1;
      for (int i = 0; i < VALUE_BITS; i++) begin
         if (((x >> i) & fixed_t'(1)) != fixed_t'(0)) idx = i;
      end
      return idx;
   endfunction

   // Power-of-two guess 2^-ceil(e/2) with e the binary exponent of x; keeps g^2*x < 2.
   function automatic fixed_t rsqrt_seed(fixed_t x);
      int p;
      int e;
      int k;
      p = leading_one_index(x);
      e = p - FRAC_BITS;
      k = FRAC_BITS - ((e + 1) >>> 1);
      if (k > VALUE_BITS - 2) return fixed_t'(1) << (VALUE_BITS - 2);
      else if (k < 0)         return fixed_t'(1);
      else                    return fixed_t'(1) << k;
   endfunction

endpackage

// File: rtl/rsqrt_seeded_iterator_newton.sv
// One Newton-Raphson refinement of 1/sqrt(x): g' = g * (3 - x*g*g) / 2, three sequential multiplies.
// Each multiply is given multiply_latency cycles; output_valid pulses for one cycle when g' is ready.
module newtons_method_rsqrt
   import rsqrt_seeded_iterator_pkg::*;
#(
   parameter int multiply_latency = 2,
   parameter bit reset_polarity   = 1'b1
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   input_valid,
   output logic   input_ready,
   input  fixed_t number,
   input  fixed_t old_guess,
   output logic   output_valid,
   output fixed_t new_guess
);

   localparam int     ML    = (multiply_latency < 1) ? 1 : multiply_latency;
   localparam int     CW    = $clog2(ML + 1);
   localparam fixed_t THREE = fixed_t'(3) <<< FRAC_BITS;

   logic                           w_rst;
   logic                           r_busy;
   logic                           r_ovalid;
   logic [1:0]                     r_phase;
   logic [CW-1:0]                  r_cnt;
   fixed_t                         r_x;
   fixed_t                         r_g;
   fixed_t                         r_acc;
   fixed_t                         w_mul_a;
   fixed_t                         w_mul_b;
   logic signed [2*VALUE_BITS-1:0] w_prod;
   fixed_t                         w_step;
   logic                           w_last;

   assign w_rst  = (reset == reset_polarity);
   assign w_last = r_busy && (r_cnt == CW'(ML - 1));

   // Phase 0: x*g, phase 1: (x*g)*g, phase 2: g*(3 - x*g*g) with the extra halving shift.
   always_comb begin
      w_mul_a = r_g;
      w_mul_b = THREE - r_acc;
      case (r_phase)
         2'd0: begin
            w_mul_a = r_x;
            w_mul_b = r_g;
         end
         2'd1: begin
            w_mul_a = r_acc;
            w_mul_b = r_g;
         end
         default: ;
      endcase
   end

   assign w_prod = w_mul_a * w_mul_b;
   assign w_step = (r_phase == 2'd2) ? fixed_t'(w_prod >>> (FRAC_BITS + 1))
                                     : fixed_t'(w_prod >>> FRAC_BITS);

   always_ff @(posedge clock) begin
      if (w_rst) begin
         r_busy   <= 1'b0;
         r_ovalid <= 1'b0;
         r_phase  <= 2'd0;
         r_cnt    <= '0;
      end else begin
         r_ovalid <= 1'b0;
         if (!r_busy) begin
            if (input_valid) begin
               r_busy  <= 1'b1;
               r_phase <= 2'd0;
               r_cnt   <= '0;
            end
         end else if (w_last) begin
            r_cnt <= '0;
            if (r_phase == 2'd2) begin
               r_busy   <= 1'b0;
               r_ovalid <= 1'b1;
            end else begin
               r_phase <= r_phase + 2'd1;
            end
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!r_busy && input_valid) begin
         r_x <= number;
         r_g <= old_guess;
      end
      if (w_last) r_acc <= w_step;
   end

   assign input_ready  = !r_busy;
   assign output_valid = r_ovalid;
   assign new_guess    = r_acc;

endmodule

// File: rtl/rsqrt_seeded_iterator.sv
// 1/sqrt(x) for positive Q16.16 operands: power-of-two seed followed by a fixed number of Newton passes.
// Non-positive operands return error=1, result=0 without touching the Newton stage.
module rsqrt_seeded_iterator
   import rsqrt_seeded_iterator_pkg::*;
#(
   parameter int iterations       = 4,
   parameter int multiply_latency = value_bits() / 16
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   input_valid,
   input  fixed_t number,
   output logic   input_ready,
   output logic   output_valid,
   input  logic   output_ready,
   output fixed_t result,
   output logic   error
);

   localparam int CNT_W = (iterations < 1) ? 1 : $clog2(iterations + 1);

   state_t           r_state;
   state_t           w_next;
   fixed_t           r_x;
   fixed_t           r_guess;
   logic             r_error;
   logic [CNT_W-1:0] r_cnt;
   logic             w_child_valid;
   logic             w_child_ready;
   logic             w_child_ovalid;
   fixed_t           w_new_guess;

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // ACK exists so a still-high child output_valid from the previous pass is never mistaken for this one.
   always_comb begin
      w_next        = r_state;
      w_child_valid = 1'b0;
      case (r_state)
         S_IDLE:  if (input_valid) w_next = (number <= fixed_t'(0)) ? S_DONE : S_SEED;
         S_SEED:  w_next = (iterations == 0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (w_child_ready) begin
            w_child_valid = 1'b1;
            w_next        = S_ACK;
         end
         S_ACK:   if (!w_child_ready) w_next = S_WAIT;
         S_WAIT:  if (w_child_ovalid) w_next = (r_cnt == CNT_W'(1)) ? S_DONE : S_ISSUE;
         S_DONE:  if (output_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // r_x and r_guess only ever hold one() or validated positive values, so the child never sees x <= 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_x     <= one();
         r_guess <= one();
         r_error <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (input_valid) begin
               if (number <= fixed_t'(0)) begin
                  r_error <= 1'b1;
               end else begin
                  r_error <= 1'b0;
                  r_x     <= number;
               end
            end
            S_SEED: begin
               r_guess <= rsqrt_seed(r_x);
               r_cnt   <= CNT_W'(iterations);
            end
            S_WAIT: if (w_child_ovalid) begin
               r_guess <= w_new_guess;
               r_cnt   <= r_cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   newtons_method_rsqrt #(
      .multiply_latency (multiply_latency),
      .reset_polarity   (1'b1)
   ) u_newton (
      .clock        (clock),
      .reset        (reset),
      .input_valid  (w_child_valid),
      .input_ready  (w_child_ready),
      .number       (r_x),
      .old_guess    (r_guess),
      .output_valid (w_child_ovalid),
      .new_guess    (w_new_guess)
   );

   assign input_ready  = (r_state == S_IDLE);
   assign output_valid = (r_state == S_DONE);
   assign error        = output_valid && r_error;
   assign result       = (output_valid && !r_error) ? r_guess : fixed_t'(0);

endmodule
